// File: rtl/mst_tx_arbiter.sv
// mst_tx_arbiter
//
// Round-robin arbiter and write sequencer for the master FIFO TX port.
// Several byte-stream requesters share one synchronous-245 write interface
// (TXE#/WR#/DATA). Each grant is a bounded burst of at most BURST_LEN beats.
// An optional busy watchdog drops a grant when the FIFO holds TXE# high for
// TIMEOUT consecutive cycles.
//
// Optional feature macro: MST_TX_ARB_WATCHDOG_EN
//   defined   - busy counter and watchdog release compiled in, timeout_o pulses
//   undefined - no busy counter, timeout_o tied low, grants wait out any stall
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req_valid_i  per-requester byte available
//   req_data_i   per-requester byte, requester k on bits [8k+7:8k]
//   req_ready_o  per-requester byte accepted this cycle (combinational)
//   txe_n_i      FIFO TXE#, low when the FIFO can take a byte
//   wr_n_o       FIFO WR#, low when a byte is written this edge (combinational)
//   data_o       FIFO data, grantee's byte during a burst, 0 when idle
//   grant_o      one-hot current grantee, 0 when idle
//   active_o     high while a burst is in progress
//   timeout_o    one-cycle pulse in the first idle cycle after a watchdog release

module mst_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic                txe_n_i,
    output logic                wr_n_o,
    output logic [7:0]          data_o,
    output logic [NREQ-1:0]     grant_o,
    output logic                active_o,
    output logic                timeout_o
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    // Reject out-of-range configurations at elaboration time.
    if (NREQ < 2 || NREQ > 4 || BURST_LEN < 1 || BURST_LEN > 255 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("mst_tx_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [NREQ-1:0] grant_q;
    logic [7:0]      beat_cnt;
    logic            gnt_valid;
    logic            beat;
    logic            burst_done;
    logic            drained;
    logic            wd_release;
    logic            release_x;

    assign gnt_valid  = req_valid_i[gidx];
    assign beat       = (state == XFER) && gnt_valid && !txe_n_i;
    // The last beat of a burst is the one that brings the count to BURST_LEN.
    assign burst_done = beat && (beat_cnt == 8'(BURST_LEN - 1));
    assign drained    = (state == XFER) && !gnt_valid;
    assign release_x  = burst_done || drained || wd_release;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid_i[(int'(ptr) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_found) state_nxt = XFER;
            XFER: if (release_x)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; the handshake towards requester and FIFO is combinational
    // so the first beat can happen in the very first cycle of a grant.
    always_comb begin
        req_ready_o = '0;
        if (beat) req_ready_o[gidx] = 1'b1;
        wr_n_o   = ~beat;
        data_o   = (state == XFER) ? req_data_i[int'(gidx)*8 +: 8] : 8'h00;
        active_o = (state == XFER);
        grant_o  = grant_q;
    end

    // Grant bookkeeping: grantee index, one-hot grant, round-robin pointer
    // and beat count. Any release clears the grant and moves the pointer past
    // the grantee so a waiting peer gets the next turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            gidx     <= '0;
            ptr      <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gidx     <= pick_idx;
                        grant_q  <= NREQ'(1) << pick_idx;
                        beat_cnt <= '0;
                    end
                end
                XFER: begin
                    if (release_x) begin
                        grant_q  <= '0;
                        ptr      <= IW'((int'(gidx) + 1) % NREQ);
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: grant_q <= '0;
            endcase
        end
    end

`ifdef MST_TX_ARB_WATCHDOG_EN
    logic [15:0] busy_cnt;
    logic        timeout_q;

    // A drained requester takes priority over the watchdog, hence gnt_valid.
    // A beat needs txe_n_i low, so it can never coincide with this.
    assign wd_release = (state == XFER) && gnt_valid && txe_n_i &&
                        (busy_cnt == 16'(TIMEOUT - 1));
    assign timeout_o  = timeout_q;

    // Busy counter counts consecutive stalled cycles of the current grant.
    // It is cleared on every release, so it never reaches TIMEOUT and cannot
    // wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_release;
            if (state != XFER || release_x || !txe_n_i) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_cnt + 16'd1;
            end
        end
    end
`else
    assign wd_release = 1'b0;
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mst_tx_arbiter.sv
// Directed testbench for mst_tx_arbiter with NREQ=2, BURST_LEN=4, TIMEOUT=8.
// Inputs are driven 1 ns after the rising edge and outputs are sampled on the
// falling edge. The watchdog scenario runs when MST_TX_ARB_WATCHDOG_EN is
// defined, the compiled-out scenario otherwise.

module tb_mst_tx_arbiter;

    localparam int NREQ      = 2;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [15:0]     req_data;
    logic [1:0]      req_ready;
    logic            txe_n;
    logic            wr_n;
    logic [7:0]      data;
    logic [1:0]      grant;
    logic            active;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mst_tx_arbiter #(
        .NREQ      (NREQ),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .txe_n_i     (txe_n),
        .wr_n_o      (wr_n),
        .data_o      (data),
        .grant_o     (grant),
        .active_o    (active),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs idle.
    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        txe_n     = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Reset values, sampled while reset is still asserted.
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'hFFFF;
        txe_n     = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_grant got %b expected 00", grant); end
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active got %b expected 0", active); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout got %b expected 0", timeout); end
        n_checks++;
        if (wr_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wr_n got %b expected 1", wr_n); end
        n_checks++;
        if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready got %b expected 00", req_ready); end
        n_checks++;
        if (data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h expected 00", data); end
        next_cycle();
        rst       = 1'b0;
        req_valid = 2'b00;
        next_cycle();
    endtask

    // req0 sends A1, A2, A3 then drops valid.
    task automatic test_basic_burst();
        logic [7:0] bytes [5] = '{8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        logic       vld   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] e_gnt [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic       e_wrn [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] e_dat [6] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 5) ? {1'b0, vld[c]} : 2'b00;
            req_data  = (c < 5) ? {8'h00, bytes[c]} : 16'h0000;
            txe_n     = 1'b0;
            @(negedge clk);
            n_checks++;
            if (grant !== e_gnt[c]) begin n_fail++; $display("[TB] FAIL basic_grant cycle %0d got %b expected %b", c, grant, e_gnt[c]); end
            n_checks++;
            if (wr_n !== e_wrn[c]) begin n_fail++; $display("[TB] FAIL basic_wr_n cycle %0d got %b expected %b", c, wr_n, e_wrn[c]); end
            if (!e_wrn[c]) begin
                n_checks++;
                if (data !== e_dat[c]) begin n_fail++; $display("[TB] FAIL basic_data cycle %0d got %h expected %h", c, data, e_dat[c]); end
            end
            next_cycle();
        end
    endtask

    // Both requesters valid continuously: 4 beats each, 1 idle cycle between.
    task automatic test_round_robin();
        logic [1:0] e_gnt [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        logic [7:0] e_dat;
        apply_reset();
        req_valid = 2'b11;
        req_data  = 16'hC33C;
        txe_n     = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e_dat = (e_gnt[c] == 2'b01) ? 8'h3C : (e_gnt[c] == 2'b10) ? 8'hC3 : 8'h00;
            n_checks++;
            if (grant !== e_gnt[c]) begin n_fail++; $display("[TB] FAIL rr_grant cycle %0d got %b expected %b", c, grant, e_gnt[c]); end
            n_checks++;
            if (req_ready !== e_gnt[c]) begin n_fail++; $display("[TB] FAIL rr_ready cycle %0d got %b expected %b", c, req_ready, e_gnt[c]); end
            n_checks++;
            if (wr_n !== (e_gnt[c] == 2'b00)) begin n_fail++; $display("[TB] FAIL rr_wr_n cycle %0d got %b expected %b", c, wr_n, e_gnt[c] == 2'b00); end
            n_checks++;
            if (data !== e_dat) begin n_fail++; $display("[TB] FAIL rr_data cycle %0d got %h expected %h", c, data, e_dat); end
            next_cycle();
        end
        req_valid = 2'b00;
        next_cycle();
    endtask

    // Stall of 5 cycles after beat 2 of 0x10..0x13; no byte lost or repeated.
    task automatic test_stall();
        logic       e_txe [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] bytes [11] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h13, 8'h00};
        logic       e_wrn [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] e_dat [11] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h13, 8'h00};
        logic [1:0] e_gnt [11] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        apply_reset();
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 10) ? 2'b01 : 2'b00;
            req_data  = {8'h00, bytes[c]};
            txe_n     = e_txe[c];
            @(negedge clk);
            n_checks++;
            if (wr_n !== e_wrn[c]) begin n_fail++; $display("[TB] FAIL stall_wr_n cycle %0d got %b expected %b", c, wr_n, e_wrn[c]); end
            n_checks++;
            if (req_ready !== {1'b0, ~e_wrn[c]}) begin n_fail++; $display("[TB] FAIL stall_ready cycle %0d got %b expected %b", c, req_ready, {1'b0, ~e_wrn[c]}); end
            n_checks++;
            if (data !== e_dat[c]) begin n_fail++; $display("[TB] FAIL stall_data cycle %0d got %h expected %h", c, data, e_dat[c]); end
            n_checks++;
            if (grant !== e_gnt[c]) begin n_fail++; $display("[TB] FAIL stall_grant cycle %0d got %b expected %b", c, grant, e_gnt[c]); end
            next_cycle();
        end
    endtask

`ifdef MST_TX_ARB_WATCHDOG_EN
    // TXE# held high: release on the 8th busy cycle, one timeout pulse, then req1.
    task automatic test_watchdog();
        logic [1:0] e_gnt;
        logic       e_to;
        apply_reset();
        req_valid = 2'b11;
        req_data  = 16'hBBAA;
        txe_n     = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e_gnt = (c >= 1 && c <= 8) ? 2'b01 : (c >= 10) ? 2'b10 : 2'b00;
            e_to  = (c == 9);
            n_checks++;
            if (grant !== e_gnt) begin n_fail++; $display("[TB] FAIL wd_grant cycle %0d got %b expected %b", c, grant, e_gnt); end
            n_checks++;
            if (timeout !== e_to) begin n_fail++; $display("[TB] FAIL wd_timeout cycle %0d got %b expected %b", c, timeout, e_to); end
            n_checks++;
            if (wr_n !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_wr_n cycle %0d got %b expected 1", c, wr_n); end
            next_cycle();
        end
        txe_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10 || data !== 8'hBB) begin
            n_fail++;
            $display("[TB] FAIL wd_resume got ready %b data %h expected ready 10 data bb", req_ready, data);
        end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
    endtask
`else
    // Watchdog compiled out: 100 stalled cycles keep the grant, no timeout.
    task automatic test_no_watchdog();
        apply_reset();
        req_valid = 2'b01;
        req_data  = 16'h005A;
        txe_n     = 1'b1;
        for (int c = 0; c < 101; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== ((c == 0) ? 2'b00 : 2'b01)) begin n_fail++; $display("[TB] FAIL nowd_grant cycle %0d got %b expected %b", c, grant, (c == 0) ? 2'b00 : 2'b01); end
            n_checks++;
            if (timeout !== 1'b0 || wr_n !== 1'b1) begin n_fail++; $display("[TB] FAIL nowd_stall cycle %0d got timeout %b wr_n %b expected 0 1", c, timeout, wr_n); end
            next_cycle();
        end
        txe_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_n !== 1'b0 || data !== 8'h5A || req_ready !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL nowd_resume got wr_n %b data %h ready %b expected 0 5a 01", wr_n, data, req_ready);
        end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
    endtask
`endif

    // req1 granted, reset after beat 2; afterwards req0 wins because ptr is 0.
    task automatic test_reset_mid_burst();
        apply_reset();
        req_valid = 2'b10;
        req_data  = 16'h5500;
        txe_n     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_checks++;
                if (grant !== 2'b10 || wr_n !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_pre cycle %0d got grant %b wr_n %b expected 10 0", c, grant, wr_n); end
            end
            next_cycle();
        end
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'h5566;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_grant got %b expected 00", grant); end
        n_checks++;
        if (wr_n !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_wr_n got %b expected 1", wr_n); end
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_active got %b expected 0", active); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_after_grant got %b expected 01", grant); end
        n_checks++;
        if (data !== 8'h66) begin n_fail++; $display("[TB] FAIL mid_after_data got %h expected 66", data); end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        txe_n     = 1'b0;
        test_reset();
        test_basic_burst();
        test_round_robin();
        test_stall();
`ifdef MST_TX_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
